// File: rtl/nonce_sweep_sched.sv
// nonce_sweep_sched: walks one SHA-256 nonce core through consecutive batches, tracking first hit and best hash.
// Best-hash tracking is compiled in only when NONCE_SWEEP_BEST_TRACK_EN is defined.
module nonce_sweep_sched #(
    parameter int NUM_NONCES = 8,
    parameter int IDX_W      = $clog2(NUM_NONCES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic [31:0]      nonce_start,
    input  logic [31:0]      nonce_count,
    input  logic [31:0]      target,
    output logic             core_start,
    output logic [31:0]      core_nonce_base,
    input  logic             core_done,
    input  logic             res_valid,
    input  logic [IDX_W-1:0] res_idx,
    input  logic [31:0]      res_h0,
    output logic             busy,
    output logic             found,
    output logic [31:0]      found_nonce,
    output logic [31:0]      best_h0,
    output logic [31:0]      best_nonce,
    output logic [15:0]      batches_done,
    output logic             sweep_done
);
    // state     | meaning
    // IDLE      | waiting for go; pending abort cleared
    // ISSUE     | pulse core_start with the current base
    // WAIT_BUSY | waiting for the core to leave idle; results collected
    // WAIT_DONE | core working; results collected until it returns idle
    // NEXT      | advance base/remaining, choose next batch or finish
    // FINISH    | one-cycle sweep_done
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_NEXT      = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;

    localparam logic [31:0] BATCH = 32'(NUM_NONCES);

    logic [2:0]  state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] target_q, target_d;
    logic        abort_pend_q, abort_pend_d;
    logic        found_q, found_d;
    logic [31:0] found_nonce_q, found_nonce_d;
    logic [15:0] batches_q, batches_d;

    logic        sweep_start;
    logic        res_take;
    logic [31:0] res_idx_ext;
    logic [31:0] res_nonce;
    logic [31:0] step;

    assign sweep_start = (state_q == S_IDLE) && go;
    assign res_idx_ext = {{(32-IDX_W){1'b0}}, res_idx};
    assign res_nonce   = base_q + res_idx_ext;
    // Indices beyond what is left of the sweep belong to a partial last batch.
    assign res_take    = res_valid && (res_idx_ext < remaining_q) &&
                         ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE));
    assign step        = (remaining_q < BATCH) ? remaining_q : BATCH;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        remaining_d   = remaining_q;
        target_d      = target_q;
        abort_pend_d  = abort_pend_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        batches_d     = batches_q;
        case (state_q)
            S_IDLE: begin
                abort_pend_d = 1'b0;
                if (sweep_start) begin
                    base_d        = nonce_start;
                    remaining_d   = nonce_count;
                    target_d      = target;
                    found_d       = 1'b0;
                    found_nonce_d = '0;
                    batches_d     = '0;
                    state_d       = (nonce_count == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: state_d = abort ? S_FINISH : S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (abort) abort_pend_d = 1'b1;
                if (!core_done) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (abort) abort_pend_d = 1'b1;
                if (core_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (batches_q != 16'hFFFF) batches_d = batches_q + 16'd1;
                base_d      = base_q + BATCH;
                remaining_d = remaining_q - step;
                state_d     = ((remaining_d == '0) || found_q || abort_pend_q || abort)
                              ? S_FINISH : S_ISSUE;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (res_take && !found_q && (res_h0 < target_q)) begin
            found_d       = 1'b1;
            found_nonce_d = res_nonce;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            remaining_q   <= '0;
            target_q      <= '0;
            abort_pend_q  <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            batches_q     <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            remaining_q   <= remaining_d;
            target_q      <= target_d;
            abort_pend_q  <= abort_pend_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            batches_q     <= batches_d;
        end
    end

`ifdef NONCE_SWEEP_BEST_TRACK_EN
    logic [31:0] best_h0_q, best_nonce_q;

    // Strict less-than keeps the earlier result on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_h0_q    <= 32'hFFFF_FFFF;
            best_nonce_q <= '0;
        end else if (sweep_start) begin
            best_h0_q    <= 32'hFFFF_FFFF;
            best_nonce_q <= '0;
        end else if (res_take && (res_h0 < best_h0_q)) begin
            best_h0_q    <= res_h0;
            best_nonce_q <= res_nonce;
        end
    end

    assign best_h0    = best_h0_q;
    assign best_nonce = best_nonce_q;
`else
    assign best_h0    = 32'hFFFF_FFFF;
    assign best_nonce = '0;
`endif

    assign core_start      = (state_q == S_ISSUE) && !abort;
    assign core_nonce_base = base_q;
    assign busy            = (state_q != S_IDLE);
    assign sweep_done      = (state_q == S_FINISH);
    assign found           = found_q;
    assign found_nonce     = found_nonce_q;
    assign batches_done    = batches_q;

endmodule
